apb_txn_master: RTL and testbench

Parametrised APB master that turns a queue of register commands into APB transfers for the encoder/decoder under test. It supersedes the stimulus-side APB driving: commands are buffered in a FIFO, wait states are supported through `pready`, and stalled transfers time out. It sits between the stimulus generator and the ECC block's APB slave port.

---
 rtl/apb_txn_master_if.sv | 40 ++++
 rtl/apb_txn_master.sv | 157 +++++++++++++++
 tb/tb_apb_txn_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_txn_master_if.sv
// rtl/apb_txn_master_if.sv - command/response and APB signal bundle for apb_txn_master
// Ports (master view):
//   cmd_valid/cmd_write/cmd_addr/cmd_wdata in, cmd_ready out : command queue push
//   rsp_valid/rsp_write/rsp_rdata/rsp_err out                 : completion pulse
//   busy out                                                  : work pending
//   psel/penable/pwrite/paddr/pwdata out, prdata/pready in    : APB bus
interface apb_txn_master_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;
    logic                       rsp_valid;
    logic                       rsp_write;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       rsp_err;
    logic                       busy;
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] paddr;
    logic [AMBA_WORD-1:0]       pwdata;
    logic [AMBA_WORD-1:0]       prdata;
    logic                       pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_txn_master.sv
// rtl/apb_txn_master.sv - queued APB master with wait states and stall timeout
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : apb_txn_master_if.master (command queue, response pulse, busy, APB)
module apb_txn_master #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 32,
    parameter int CMD_DEPTH       = 8,
    parameter int TIMEOUT         = 16
) (
    input logic                clk,
    input logic                rst,
    apb_txn_master_if.master   bus
);
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam int ENT_W  = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(CMD_DEPTH);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                      state_q, state_d;
    logic [ENT_W-1:0]            mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]              count_q, count_d;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic                        pwrite_q;
    logic [AMBA_ADDR_WIDTH-1:0]  paddr_q;
    logic [AMBA_WORD-1:0]        pwdata_q;
    logic                        rsp_valid_q, rsp_write_q, rsp_err_q;
    logic [AMBA_WORD-1:0]        rsp_rdata_q;

    logic                        push, pop, done, abort, fifo_empty;
    logic                        psel_c, penable_c;
    logic                        head_write;
    logic [AMBA_ADDR_WIDTH-1:0]  head_addr;
    logic [AMBA_WORD-1:0]        head_wdata;

    assign fifo_empty = (count_q == '0);
    // Readiness comes from the registered count only, so a pop in the
    // same cycle never makes room for a push to a full queue.
    assign bus.cmd_ready = (count_q != FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign count_d       = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign {head_write, head_addr, head_wdata} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    // State register (plus datapath registers sharing the same reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            rsp_valid_q <= done || abort;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                pwrite_q <= head_write;
                paddr_q  <= head_addr;
                pwdata_q <= head_wdata;
            end
            if (done || abort) begin
                rsp_write_q <= pwrite_q;
                rsp_err_q   <= abort;
                rsp_rdata_q <= (done && !pwrite_q) ? bus.prdata : '0;
            end
        end
    end

    // Next-state logic. The completion path pops straight into SETUP so
    // back-to-back commands run with no IDLE cycle between them.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop     = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                wait_d  = '0;
            end
            S_ACCESS: begin
                // pready has priority over an expiring timeout.
                if (bus.pready) begin
                    done = 1'b1;
                end else if (wait_q == LAST_WAIT) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (bus.pready || (wait_q == LAST_WAIT)) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: control follows state directly so reset drops it at once.
    always_comb begin
        psel_c    = 1'b0;
        penable_c = 1'b0;
        case (state_q)
            S_SETUP:  psel_c = 1'b1;
            S_ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.psel      = psel_c;
    assign bus.penable   = penable_c;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_apb_txn_master.sv
// tb/tb_apb_txn_master.sv - self-checking bench for apb_txn_master
module tb_apb_txn_master;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    apb_txn_master_if #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW)) bus ();

    apb_txn_master #(
        .AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
    } setup_t;

    typedef struct {
        int            cyc;
        logic          wr;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stab_bad = 0;

    setup_t        obs_setup[$];
    rsp_t          obs_rsp[$];
    int            plan_wait[$];
    logic [DW-1:0] plan_data[$];
    int            cur_wait = 0;
    int            acc_cnt  = 0;
    logic [DW-1:0] cur_data = '0;

    // Reference model: per accepted command, push cycle, SETUP cycle, ACCESS length.
    int            m_p[$], m_s[$], m_l[$];
    logic          m_w[$], m_e[$];
    logic [AW-1:0] m_a[$];
    logic [DW-1:0] m_d[$], m_r[$];
    int            last_e = -100;

    // APB slave responder and bus monitor.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            bus.pready = 1'b0;
            acc_cnt    = 0;
        end else begin
            if (bus.psel && !bus.penable) begin
                obs_setup.push_back('{cyc, bus.paddr, bus.pwdata, bus.pwrite});
                if (plan_wait.size() > 0) begin
                    cur_wait = plan_wait.pop_front();
                    cur_data = plan_data.pop_front();
                end else begin
                    cur_wait = 0;
                    cur_data = '0;
                end
                acc_cnt = 0;
            end
            if (bus.psel && bus.penable) begin
                bus.pready = (acc_cnt >= cur_wait);
                bus.prdata = bus.pready ? cur_data : ~cur_data;
                acc_cnt++;
                if (obs_setup.size() > 0) begin
                    if (bus.paddr !== obs_setup[$].addr || bus.pwdata !== obs_setup[$].wdata ||
                        bus.pwrite !== obs_setup[$].wr)
                        stab_bad++;
                end
            end else begin
                bus.pready = 1'b0;
                bus.prdata = $urandom();
            end
            if (!bus.psel && bus.penable) stab_bad++;
            if (bus.rsp_valid) obs_rsp.push_back('{cyc, bus.rsp_write, bus.rsp_rdata, bus.rsp_err});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int model_count(input int c);
        int n = 0;
        foreach (m_p[i]) begin
            if (m_p[i] < c) n++;
            if (m_s[i] - 1 < c) n--;
        end
        return n;
    endfunction

    function automatic logic model_busy(input int c);
        logic b = 1'b0;
        foreach (m_p[i]) if (m_p[i] < c && c <= m_s[i] + m_l[i]) b = 1'b1;
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            chk("busy", bus.busy, model_busy(cyc));
            step();
        end
    endtask

    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int wt, input logic [DW-1:0] rd, output bit acc);
        int s, l;
        acc = (model_count(cyc) != DEPTH);
        chk("cmd_ready", bus.cmd_ready, acc);
        chk("busy", bus.busy, model_busy(cyc));
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        if (acc) begin
            s = (cyc + 2 > last_e + 1) ? cyc + 2 : last_e + 1;
            l = (wt >= TMO) ? TMO : wt + 1;
            last_e = s + l;
            m_p.push_back(cyc); m_s.push_back(s); m_l.push_back(l);
            m_w.push_back(w); m_a.push_back(a); m_d.push_back(d);
            m_r.push_back((!w && wt < TMO) ? rd : '0);
            m_e.push_back(wt >= TMO);
            plan_wait.push_back(wt);
            plan_data.push_back(rd);
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_phase();
        int guard = 0;
        while (cyc <= last_e + 2 && guard < 2000) begin
            idle(1);
            guard++;
        end
        chk("drain_bound", guard < 2000, 1'b1);
        chk("n_setup", obs_setup.size(), m_p.size());
        chk("n_rsp", obs_rsp.size(), m_p.size());
        chk("apb_stable", stab_bad, 0);
        foreach (m_p[i]) begin
            if (i < obs_setup.size() && i < obs_rsp.size()) begin
                chk("setup_cyc", obs_setup[i].cyc, m_s[i]);
                chk("paddr", obs_setup[i].addr, m_a[i]);
                chk("pwrite", obs_setup[i].wr, m_w[i]);
                if (m_w[i]) chk("pwdata", obs_setup[i].wdata, m_d[i]);
                chk("rsp_cyc", obs_rsp[i].cyc, m_s[i] + m_l[i] + 1);
                chk("rsp_write", obs_rsp[i].wr, m_w[i]);
                chk("rsp_rdata", obs_rsp[i].rdata, m_r[i]);
                chk("rsp_err", obs_rsp[i].err, m_e[i]);
            end
        end
    endtask

    task automatic clear_phase();
        m_p.delete(); m_s.delete(); m_l.delete(); m_w.delete(); m_e.delete();
        m_a.delete(); m_d.delete(); m_r.delete();
        obs_setup.delete(); obs_rsp.delete();
    endtask

    initial begin
        bit acc;
        int p0, tries, acc_cyc, n0, c;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.pready = 1'b0; bus.prdata = '0;
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_psel", bus.psel, 0);       chk("rst_penable", bus.penable, 0);
        chk("rst_pwrite", bus.pwrite, 0);   chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);   chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_write", bus.rsp_write, 0); chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0); chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        idle(2);

        // Single zero-wait write.
        push_cmd(1'b1, 32'h4, 32'hDEADBEEF, 0, 32'h0, acc);
        step();
        chk("w_setup_psel", bus.psel, 1); chk("w_setup_penable", bus.penable, 0);
        chk("w_paddr", bus.paddr, 32'h4); chk("w_pwdata", bus.pwdata, 32'hDEADBEEF);
        chk("w_pwrite", bus.pwrite, 1);
        step();
        chk("w_access_psel", bus.psel, 1); chk("w_access_penable", bus.penable, 1);
        step();
        chk("w_rsp_valid", bus.rsp_valid, 1); chk("w_rsp_write", bus.rsp_write, 1);
        chk("w_rsp_rdata", bus.rsp_rdata, 0); chk("w_rsp_err", bus.rsp_err, 0);
        step();
        chk("w_rsp_pulse", bus.rsp_valid, 0);
        check_phase(); clear_phase();

        // Read with two wait states.
        push_cmd(1'b0, 32'h8, 32'h0, 2, 32'h12345678, acc);
        check_phase();
        chk("r_access_len", obs_rsp[0].cyc - obs_setup[0].cyc - 1, 3);
        chk("r_rdata", obs_rsp[0].rdata, 32'h12345678);
        clear_phase();

        // Three back-to-back zero-wait commands.
        for (int k = 0; k < 3; k++) push_cmd(k[0], $urandom(), $urandom(), 0, $urandom(), acc);
        check_phase();
        chk("b2b_setup_gap", obs_setup[1].cyc - obs_setup[0].cyc, 2);
        chk("b2b_rsp_gap1", obs_rsp[1].cyc - obs_rsp[0].cyc, 2);
        chk("b2b_rsp_gap2", obs_rsp[2].cyc - obs_rsp[1].cyc, 2);
        clear_phase();

        // pready stuck low: fill the queue, timeouts, refill after first abort.
        p0 = cyc;
        for (int k = 0; k < 9; k++) push_cmd($urandom_range(0, 1), $urandom(), $urandom(), 100, $urandom(), acc);
        chk("full_after_9", bus.cmd_ready, 0);
        tries = 0; acc = 0; acc_cyc = -1;
        while (!acc && tries < 100) begin
            c = cyc;
            push_cmd(1'b0, 32'hC, 32'h0, 100, 32'h0, acc);
            if (acc) acc_cyc = c;
            tries++;
        end
        chk("refill_cycle", acc_cyc, p0 + 2 + TMO + 1);
        check_phase();
        chk("timeout_len", obs_rsp[0].cyc - obs_setup[0].cyc - 1, TMO);
        chk("timeout_err", obs_rsp[0].err, 1);
        chk("timeout_rdata", obs_rsp[0].rdata, 0);
        chk("timeout_next_setup", obs_setup[1].cyc, obs_rsp[0].cyc);
        clear_phase();

        // Randomized traffic including waits around the timeout boundary.
        for (int k = 0; k < 60; k++) begin
            int   wt;
            logic w;
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: wt = $urandom_range(TMO - 2, TMO + 1);
                1: wt = 100;
                default: wt = $urandom_range(0, 3);
            endcase
            tries = 0; acc = 0;
            while (!acc && tries < 200) begin
                push_cmd(w, $urandom(), $urandom(), wt, $urandom(), acc);
                tries++;
            end
            chk("rand_push_accept", acc, 1);
            idle($urandom_range(0, 2));
        end
        check_phase(); clear_phase();

        // Reset during ACCESS with three commands queued.
        for (int k = 0; k < 4; k++) push_cmd(1'b1, $urandom(), $urandom(), 100, 32'h0, acc);
        step();
        chk("pre_rst_psel", bus.psel, 1); chk("pre_rst_penable", bus.penable, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_psel", bus.psel, 0); chk("arst_penable", bus.penable, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 1); chk("arst_busy", bus.busy, 0);
        n0 = obs_rsp.size();
        step(); step();
        rst = 1'b0;
        clear_phase();
        plan_wait.delete(); plan_data.delete();
        last_e = -100;
        n0 = 0;
        idle(30);
        chk("no_rsp_after_reset", obs_rsp.size(), n0);
        chk("no_setup_after_reset", obs_setup.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
